pipe_skid_reg: RTL and testbench

//  Two-entry valid/ready pipeline register (skid buffer) placed between CPU pipeline stages,

---
 rtl/pipe_skid_reg_if.sv | 24 ++
 rtl/pipe_skid_reg.sv | 95 +++++++++
 tb/tb_pipe_skid_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for the two-entry skid stage.
// The slave modport is the stage's view and the master modport is the surrounding pipeline's view.
interface pipe_skid_reg_if #(
  parameter int unsigned width = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic [1:0]       count;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages. The upstream ready comes from a flop,
// so no combinational ready path crosses the stage. The stage is in-order and has one cycle of latency.
module pipe_skid_reg #(
  parameter int unsigned width = 32
) (
  input  logic                clk,
  input  logic                reset,
  pipe_skid_reg_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] main_q, main_d;
  logic [width-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       count_q;
  logic             acc_in_c;
  logic             acc_out_c;

  assign acc_in_c  = bus.in_valid & in_ready_q;
  assign acc_out_c = out_valid_q & bus.out_ready;

  // Next-state and data steering; a flush empties the stage but leaves the data regs untouched.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_in_c) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (acc_in_c && acc_out_c) begin
            main_d = bus.in_data;
          end else if (acc_in_c) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (acc_out_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (acc_out_c) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered copies of the decoded next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      count_q     <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg. Directed scenarios are checked against fixed values.
// A random phase is checked against a queue model with a capacity of two words.
module tb_pipe_skid_reg;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_skid_reg_if #(.width(W)) bus ();

  pipe_skid_reg #(.width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] head_val = '0;

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  // Advance one clock and apply the queue semantics of a two-slot FIFO to the model.
  task automatic tick();
    bit ai;
    bit ao;
    @(posedge clk);
    if (reset) begin
      if (bus.flush) begin
        mq.delete();
      end else begin
        ai = bus.in_valid && (mq.size() < 2);
        ao = (mq.size() > 0) && bus.out_ready;
        if (ao) void'(mq.pop_front());
        if (ai) mq.push_back(bus.in_data);
      end
      if (mq.size() > 0) head_val = mq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, '0, 0, 0);
    #12;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst0_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst0_ready got %b exp 1", bus.in_ready); end
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL rst0_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst0_data got %h exp 0", bus.out_data); end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'hDEAD_0001, 0, 0); tick();
    drive(1, 32'hDEAD_0002, 0, 0); tick();
    n_vec++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL rst_prefill_count got %0d exp 2", bus.count); end
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    head_val = '0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_ready got %b exp 1", bus.in_ready); end
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL rst_async_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_async_data got %h exp 0", bus.out_data); end
    drive(1, 32'h1234_5678, 1, 0);
    tick();
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL rst_hold_count got %0d exp 0", bus.count); end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'hA5A5_A5A5, 0, 0);
    tick();
    drive(0, '0, 0, 0);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_valid got %b exp 1", bus.out_valid); end
    n_vec++; if (bus.out_data !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL rst_first_data got %h exp a5a5a5a5", bus.out_data); end
    n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL rst_first_count got %0d exp 1", bus.count); end
  endtask

  task automatic test_streaming();
    drive(0, '0, 1, 0); tick(); tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1, W'(i), 1, 0);
      tick();
      n_vec++; if (bus.out_data !== W'(i)) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", i, bus.out_data, W'(i)); end
      n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d exp 1", i, bus.count); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid); end
    end
    drive(0, '0, 1, 0); tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1, 32'h11, 0, 0); tick();
    drive(1, 32'h22, 0, 0); tick();
    n_vec++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL bp_count got %0d exp 2", bus.count); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b exp 0", bus.in_ready); end
    n_vec++; if (bus.out_data !== 32'h11) begin n_err++; $display("FAIL bp_data got %h exp 11", bus.out_data); end
    drive(1, 32'h33, 0, 0); tick();
    n_vec++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL bp_ignored_count got %0d exp 2", bus.count); end
    n_vec++; if (bus.out_data !== 32'h11) begin n_err++; $display("FAIL bp_stable_data got %h exp 11", bus.out_data); end
    drive(0, '0, 1, 0); tick();
    n_vec++; if (bus.out_data !== 32'h22) begin n_err++; $display("FAIL bp_second_data got %h exp 22", bus.out_data); end
    n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL bp_second_count got %0d exp 1", bus.count); end
    drive(1, 32'h33, 1, 0); tick();
    n_vec++; if (bus.out_data !== 32'h33) begin n_err++; $display("FAIL bp_third_data got %h exp 33", bus.out_data); end
    n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL bp_third_count got %0d exp 1", bus.count); end
    drive(0, '0, 1, 0); tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_simultaneous();
    drive(1, 32'h5, 0, 0); tick();
    n_vec++; if (bus.out_data !== 32'h5) begin n_err++; $display("FAIL sim_first_data got %h exp 5", bus.out_data); end
    drive(1, 32'h6, 1, 0); tick();
    n_vec++; if (bus.out_data !== 32'h6) begin n_err++; $display("FAIL sim_swap_data got %h exp 6", bus.out_data); end
    n_vec++; if (bus.count !== 2'd1) begin n_err++; $display("FAIL sim_swap_count got %0d exp 1", bus.count); end
    drive(0, '0, 1, 0); tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h77, 0, 0); tick();
    drive(1, 32'h88, 0, 0); tick();
    n_vec++; if (bus.count !== 2'd2) begin n_err++; $display("FAIL fl_full_count got %0d exp 2", bus.count); end
    drive(1, 32'h99, 1, 1); tick();
    n_vec++; if (bus.count !== 2'd0) begin n_err++; $display("FAIL fl_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready got %b exp 1", bus.in_ready); end
    n_vec++; if (bus.out_data !== 32'h77) begin n_err++; $display("FAIL fl_held_data got %h exp 77", bus.out_data); end
    drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (bus.out_valid !== 1'b0 || bus.out_data === 32'h88) begin
        n_err++; $display("FAIL fl_after[%0d] got valid=%b data=%h exp valid=0 data!=88", i, bus.out_valid, bus.out_data);
      end
    end
  endtask

  task automatic test_random();
    int unsigned popped = 0;
    for (int c = 0; c < 10000; c++) begin
      drive(bit'($urandom_range(0, 3) != 0), W'($urandom), bit'($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 63) == 0));
      if (bus.out_valid && bus.out_ready && !bus.flush) popped++;
      tick();
      n_vec++; if (bus.out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, bus.out_valid, mq.size() > 0); end
      n_vec++; if (bus.in_ready !== (mq.size() < 2)) begin n_err++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.in_ready, mq.size() < 2); end
      n_vec++; if (bus.count !== 2'(mq.size())) begin n_err++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.count, mq.size()); end
      n_vec++; if (bus.out_data !== head_val) begin n_err++; $display("FAIL rnd_data c%0d got %h exp %h", c, bus.out_data, head_val); end
    end
    n_vec++; if (popped == 0) begin n_err++; $display("FAIL rnd_traffic got %0d pops exp >0", popped); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
